// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: multi-cycle MIPS control FSM with memory handshake,
// stall, bus-timeout/illegal-opcode traps and a retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                retire,
    output logic [CNT_W-1:0]    retire_count,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] C_OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] C_OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] C_OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] C_OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] C_OP_XORI  = OPCODE_W'(6'b001110);
    localparam logic [OPCODE_W-1:0] C_OP_J     = OPCODE_W'(6'b000010);
    localparam logic [TO_W-1:0]     C_TO_LIM   = TO_W'(TIMEOUT);
    localparam bit                  C_TO_EN    = (TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              w_mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        count_d     = count_q;
        retire      = 1'b0;
        w_mem_wait  = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = '0;
        PCSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                w_mem_wait = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (Opcode == C_OP_RTYPE)                        state_d = S_EXEC;
                else if (Opcode == C_OP_LW || Opcode == C_OP_SW) state_d = S_MEMADR;
                else if (Opcode == C_OP_BNE)                     state_d = S_BRANCH;
                else if (Opcode == C_OP_XORI)                    state_d = S_IEXEC;
                else if (Opcode == C_OP_J)                       state_d = S_JUMP;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                w_mem_wait = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                w_mem_wait = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(2'b10);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(2'b01);
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_W'(2'b11);
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Memory wait accounting; a ready in the timeout cycle still advances.
        if (w_mem_wait && !mem_ready) begin
            if (C_TO_EN && wait_q == C_TO_LIM) begin
                state_d     = S_TRAP;
                bus_error_d = 1'b1;
            end else begin
                wait_d = wait_q + TO_W'(1);
            end
        end
        if (state_d != state_q || (w_mem_wait && mem_ready)) wait_d = '0;

        if (stall && state_q != S_TRAP) begin
            state_d     = state_q;
            wait_d      = wait_q;
            illegal_d   = illegal_q;
            bus_error_d = bus_error_q;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
        end

        // Only completing states ever move into FETCH from elsewhere.
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            retire  = 1'b1;
            count_d = count_q + CNT_W'(1);
        end
    end

    assign illegal_op   = illegal_q;
    assign bus_error    = bus_error_q;
    assign retire_count = count_q;
    assign state        = state_q;

endmodule

`default_nettype wire
